// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between the CPU memory stage and a
// word-wide synchronous data RAM. One request per transaction; performs a
// word read, a word write or a sub-word read-modify-write, and answers with
// a one-cycle response pulse (load data or fault).
// Optional build macro: LSU_ALIGN_CHECK_EN (enables misalignment faults).
module lsu_mem_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [1:0]        req_offset,
    input  logic [ADDR_W-1:0] req_paddr,
    input  logic              req_invalid,
    input  logic [31:0]       req_wdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              resp_valid,
    output logic              resp_fault,
    output logic [31:0]       resp_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_write;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [1:0]          r_offset;
    logic [31:0]         r_wdata;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [31:0]         r_ram_wdata;
    logic                r_resp_valid;
    logic                r_resp_fault;
    logic [31:0]         r_resp_rdata;
    logic                w_fault;

    // Shift the addressed lane of a RAM word down to bit 0 and extend it.
    function automatic logic [31:0] load_fmt(input logic [31:0] d, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = d;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane of the old RAM word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] res;
        res = old;
        case (sz)
            2'b00: res[{off, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (off[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    // Decide whether the presented request faults (bad address, reserved size, misalignment).
    always_comb begin
        w_fault = 1'b0;
        if (req_invalid || (req_size == 2'b11)) begin
            w_fault = 1'b1;
        end else begin
`ifdef LSU_ALIGN_CHECK_EN
            if ((req_size == 2'b01) && req_offset[0]) begin
                w_fault = 1'b1;
            end else if ((req_size == 2'b10) && (req_offset != 2'b00)) begin
                w_fault = 1'b1;
            end else begin
                w_fault = 1'b0;
            end
`else
            w_fault = 1'b0;
`endif
        end
    end

    // Transaction FSM: captures the request and produces all registered RAM/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_offset     <= 2'b00;
            r_wdata      <= 32'd0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_offset   <= req_offset;
                        r_wdata    <= req_wdata;
                        if (w_fault) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                        end else if (req_write && (req_size == 2'b10)) begin
                            r_state     <= S_WRITE;
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= 1'b1;
                            r_ram_addr  <= req_paddr;
                            r_ram_wdata <= req_wdata;
                        end else begin
                            r_state    <= S_READ;
                            r_ram_en   <= 1'b1;
                            r_ram_addr <= req_paddr;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_write) begin
                        r_state     <= S_WRITE;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= 1'b1;
                        r_ram_wdata <= store_merge(ram_rdata, r_wdata, r_size, r_offset);
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= load_fmt(ram_rdata, r_size, r_offset, r_unsigned);
                    end
                end
                S_WRITE: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign ram_en     = r_ram_en;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_fault = r_resp_fault;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed cases plus randomized requests,
// expected responses derived from a word-array memory model with arithmetic lane math.
module tb_lsu_mem_ctrl;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [1:0]        req_offset = 2'b00;
    logic [ADDR_W-1:0] req_paddr = '0;
    logic              req_invalid = 1'b0;
    logic [31:0]       req_wdata = 32'd0;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;
    logic              resp_valid, resp_fault;
    logic [31:0]       resp_rdata;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_offset(req_offset), .req_paddr(req_paddr), .req_invalid(req_invalid),
        .req_wdata(req_wdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .resp_valid(resp_valid),
        .resp_fault(resp_fault), .resp_rdata(resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              fault;
        logic [31:0]       rdata;
        logic [31:0]       wdata;
        logic [ADDR_W-1:0] paddr;
        int                en_cnt;
        int                due;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          pcyc = 0;
    int          en_seen = 0;
    logic [31:0] mem [0:2047];
    logic [31:0] ref_mem [0:2047];
    logic [31:0] model_rdata = 32'd0;

    // Cycle counter, stable when sampled on the falling edge.
    always @(posedge clk) pcyc <= pcyc + 1;

    // Synchronous RAM: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: checks RAM strobes against the outstanding request and pops on each response.
    always @(negedge clk) begin
        if (!rst_n) begin
            en_seen = 0;
        end else begin
            if (ram_en) begin
                en_seen++;
                if (sbq.size() > 0) begin
                    check("ram_addr", 32'(ram_addr), 32'(sbq[0].paddr));
                    if (ram_we) check("ram_wdata", ram_wdata, sbq[0].wdata);
                end
            end
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    check("stray_resp", {31'd0, resp_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_cycle", pcyc, e.due);
                    check("ram_access_count", en_seen, e.en_cnt);
                end
                en_seen = 0;
            end
        end
    end

    // Issue one request; when track is set, the model result goes to the scoreboard.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [1:0] off, input logic [ADDR_W-1:0] pa,
                          input logic inv, input logic [31:0] wd, input bit track);
        int guard = 0;
        exp_t e;
        logic f;
        int lane, lat;
        logic [31:0] mask, old, v;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("ready_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_offset = off; req_paddr = pa; req_invalid = inv; req_wdata = wd;
        if (track) begin
            f = inv || (sz == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
            if (sz == 2'b01 && off[0]) f = 1'b1;
            if (sz == 2'b10 && off != 2'b00) f = 1'b1;
`endif
            lane = (sz == 2'b00) ? int'(off) : (sz == 2'b01) ? (int'(off) / 2) * 2 : 0;
            mask = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            old = ref_mem[pa];
            e.paddr = pa;
            e.wdata = 32'd0;
            e.fault = f;
            if (f) begin
                e.en_cnt = 0; lat = 1;
            end else if (w) begin
                v = (old & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
                ref_mem[pa] = v;
                e.wdata = v;
                e.en_cnt = (sz == 2'b10) ? 1 : 2;
                lat = (sz == 2'b10) ? 2 : 4;
            end else begin
                v = (old >> (8 * lane)) & mask;
                if (!uns && ((v & ((mask >> 1) + 32'd1)) != 32'd0)) v = v | ~mask;
                model_rdata = v;
                e.en_cnt = 1; lat = 3;
            end
            e.rdata = model_rdata;
            e.due = pcyc + lat;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_offset = 2'($urandom); req_paddr = ADDR_W'($urandom); req_invalid = 1'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (sbq.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 32'(sbq.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_fault"}, {31'd0, resp_fault}, 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16] = 32'h1122_3344; ref_mem[16] = 32'h1122_3344;
        mem[32] = 32'h80FF_7F01; ref_mem[32] = 32'h80FF_7F01;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Word store then load
        do_req(1'b1, 2'b10, 1'b0, 2'd0, 11'h005, 1'b0, 32'hDEAD_BEEF, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 2'd0, 11'h005, 1'b0, 32'd0, 1'b1);
        wait_done();
        check("word_load", resp_rdata, 32'hDEAD_BEEF);

        // Sub-word store merge
        do_req(1'b1, 2'b00, 1'b0, 2'd2, 11'd16, 1'b0, 32'h0000_00AA, 1'b1);
        wait_done();
        check("byte_merge_ram", mem[16], 32'h11AA_3344);

        // Load extension
        do_req(1'b0, 2'b00, 1'b0, 2'd2, 11'd32, 1'b0, 32'd0, 1'b1);
        wait_done();
        check("byte_signed", resp_rdata, 32'hFFFF_FFFF);
        do_req(1'b0, 2'b01, 1'b0, 2'd2, 11'd32, 1'b0, 32'd0, 1'b1);
        wait_done();
        check("half_signed", resp_rdata, 32'hFFFF_80FF);
        do_req(1'b0, 2'b01, 1'b1, 2'd2, 11'd32, 1'b0, 32'd0, 1'b1);
        wait_done();
        check("half_unsigned", resp_rdata, 32'h0000_80FF);

        // Faulting store leaves RAM and load data alone
        do_req(1'b1, 2'b10, 1'b0, 2'd0, 11'd32, 1'b1, 32'h1234_5678, 1'b1);
        wait_done();
        check("fault_rdata_held", resp_rdata, 32'h0000_80FF);
        check("fault_ram_untouched", mem[32], 32'h80FF_7F01);

        // Word load at offset 1 (fault or aligned read depending on build)
        do_req(1'b0, 2'b10, 1'b0, 2'd1, 11'd16, 1'b0, 32'd0, 1'b1);
        wait_done();

        // Randomized traffic over a small address window so lanes get revisited
        for (int n = 0; n < 200; n++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                   ADDR_W'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), $urandom, 1'b1);
        end
        wait_done();

        // Reset abort in WAIT of a sub-word store
        mem[20] = 32'hCAFE_F00D; ref_mem[20] = 32'hCAFE_F00D;
        do_req(1'b1, 2'b00, 1'b0, 2'd0, 11'd20, 1'b0, 32'h0000_0055, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        model_rdata = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_write", {31'd0, ram_we}, 32'd0);
        end
        check("abort_ram_untouched", mem[20], 32'hCAFE_F00D);
        do_req(1'b0, 2'b10, 1'b0, 2'd0, 11'd20, 1'b0, 32'd0, 1'b1);
        wait_done();
        check("after_abort_load", resp_rdata, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
